// File: rtl/spi_mem_responder.sv
// Serves core load/store requests from an external SPI serial SRAM (mode 0, 24-bit address, sequential).
// Define SPI_MEM_FAST_READ_EN to issue loads as fast reads (opcode 0x0B plus 8 dummy bits).
module spi_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter logic [7:0]  WRITE_CMD  = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [2:0]  option,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        memory_response,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

`ifdef SPI_MEM_FAST_READ_EN
  localparam logic       FastRead = 1'b1;
  localparam logic [7:0] LoadCmd  = 8'h0B;
`else
  localparam logic       FastRead = 1'b0;
  localparam logic [7:0] LoadCmd  = READ_CMD;
`endif

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_e;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [63:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        is_write_q, is_write_d;
  logic [2:0]  opt_q, opt_d;
  logic [31:0] read_data_q, read_data_d;
  logic        resp_q, resp_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;

  logic        req_valid;
  logic [7:0]  cmd_byte;
  logic [23:0] addr24;
  logic [31:0] wr_bytes;
  logic [63:0] frame;
  logic [4:0]  data_last;
  logic        bit_last;
  logic        unused_addr_hi;

  // Whole outgoing frame is built at acceptance and shifted out MSB first; store bytes go low byte first.
  assign req_valid = !(option == 3'b011 || option[2:1] == 2'b11);
  assign cmd_byte  = memory_write ? WRITE_CMD : LoadCmd;
  assign addr24    = 24'(address[ADDR_WIDTH-1:0]);
  assign wr_bytes  = {write_data[7:0], write_data[15:8], write_data[23:16], write_data[31:24]};
  assign frame     = {cmd_byte, addr24, memory_write ? wr_bytes : 32'h0};
  assign data_last = (opt_q[1:0] == 2'b00) ? 5'd7 : (opt_q[1:0] == 2'b01) ? 5'd15 : 5'd31;
  assign unused_addr_hi = ^address[31:ADDR_WIDTH];

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    is_write_d  = is_write_q;
    opt_d       = opt_q;
    read_data_d = read_data_q;
    resp_d      = 1'b0;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    bit_last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memory_read || memory_write) begin
          is_write_d = memory_write;
          opt_d      = option;
          if (!req_valid) begin
            state_d = DONE;
            resp_d  = 1'b1;
            if (!memory_write) read_data_d = 32'h0;
          end else begin
            state_d   = CMD;
            cs_n_d    = 1'b0;
            sck_d     = 1'b0;
            phase_d   = 1'b0;
            bit_cnt_d = 5'd0;
            rx_d      = 32'h0;
            mosi_d    = frame[63];
            tx_d      = {frame[62:0], 1'b0};
          end
        end
      end
      CMD, ADDR, DUMMY, DATA: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          sck_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
          sck_d   = 1'b0;
          // Received bytes land little-endian, each byte arriving MSB first.
          if (state_q == DATA && !is_write_q) rx_d[{bit_cnt_q[4:3], ~bit_cnt_q[2:0]}] = spi_miso;
          unique case (state_q)
            CMD:     bit_last = (bit_cnt_q == 5'd7);
            ADDR:    bit_last = (bit_cnt_q == 5'd23);
            DUMMY:   bit_last = (bit_cnt_q == 5'd7);
            default: bit_last = (bit_cnt_q == data_last);
          endcase
          bit_cnt_d = bit_last ? 5'd0 : bit_cnt_q + 5'd1;
          if (bit_last) begin
            unique case (state_q)
              CMD:     state_d = ADDR;
              ADDR:    state_d = (FastRead && !is_write_q) ? DUMMY : DATA;
              DUMMY:   state_d = DATA;
              default: state_d = DONE;
            endcase
          end
          if (state_d == DONE) begin
            cs_n_d = 1'b1;
            mosi_d = 1'b0;
            resp_d = 1'b1;
            if (!is_write_q) begin
              unique case (opt_q[1:0])
                2'b00:   read_data_d = {{24{rx_d[7] & ~opt_q[2]}}, rx_d[7:0]};
                2'b01:   read_data_d = {{16{rx_d[15] & ~opt_q[2]}}, rx_d[15:0]};
                default: read_data_d = rx_d;
              endcase
            end
          end else if (state_d == DUMMY) begin
            mosi_d = 1'b0;
          end else begin
            mosi_d = tx_q[63];
            tx_d   = {tx_q[62:0], 1'b0};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      bit_cnt_q   <= 5'd0;
      tx_q        <= 64'h0;
      rx_q        <= 32'h0;
      is_write_q  <= 1'b0;
      opt_q       <= 3'b000;
      read_data_q <= 32'h0;
      resp_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      is_write_q  <= is_write_d;
      opt_q       <= opt_d;
      read_data_q <= read_data_d;
      resp_q      <= resp_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
    end
  end

  assign read_data       = read_data_q;
  assign memory_response = resp_q;
  assign spi_cs_n        = cs_n_q;
  assign spi_sck         = sck_q;
  assign spi_mosi        = mosi_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: SPI SRAM model, reference memory model and per-cycle output compare.
// Honours SPI_MEM_FAST_READ_EN the same way the design does.
module tb_spi_mem_responder;

`ifdef SPI_MEM_FAST_READ_EN
  localparam bit FastBuild = 1'b1;
`else
  localparam bit FastBuild = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memory_read, memory_write;
  logic [2:0]  option;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        memory_response;
  logic        spi_cs_n, spi_sck, spi_mosi;
  logic        spi_miso = 1'b0;

  spi_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .memory_read(memory_read), .memory_write(memory_write),
    .option(option), .address(address), .write_data(write_data),
    .read_data(read_data), .memory_response(memory_response),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External SRAM: 128 KiB, sequential mode, wraps at the top of the array.
  logic [7:0]  ramMem [0:131071];
  logic [7:0]  refMem [0:131071];
  int          ramBit, ramDs, ramD;
  logic [7:0]  ramCmd, ramByte, ramRd;
  logic [23:0] ramAddr;
  logic [16:0] ramIdx;
  logic [71:0] capStream;
  int          capBits;

  always @(negedge spi_cs_n) begin
    ramBit = 0; capBits = 0; capStream = 72'h0;
  end

  always @(posedge spi_sck) if (!spi_cs_n) begin
    capStream = {capStream[70:0], spi_mosi};
    capBits++;
    if (ramBit < 8) ramCmd = {ramCmd[6:0], spi_mosi};
    else if (ramBit < 32) ramAddr = {ramAddr[22:0], spi_mosi};
    else if (ramCmd == 8'h02) begin
      ramByte = {ramByte[6:0], spi_mosi};
      if (ramBit % 8 == 7) begin
        ramMem[ramAddr[16:0]] = ramByte;
        ramAddr = ramAddr + 24'd1;
      end
    end
    ramBit++;
  end

  always @(negedge spi_sck) if (!spi_cs_n) begin
    ramDs = (ramCmd == 8'h0B) ? 40 : 32;
    if ((ramCmd == 8'h03 || ramCmd == 8'h0B) && ramBit >= ramDs) begin
      ramD   = ramBit - ramDs;
      ramIdx = ramAddr[16:0] + 17'(ramD / 8);
      ramRd  = ramMem[ramIdx];
      spi_miso <= ramRd[7 - (ramD % 8)];
    end
  end

  // Transaction model state, written by the driver and read by the compare process.
  int          edgeCnt = 0;
  logic        rstSampled = 1'b0;
  int          txnAccept = -100000;
  int          txnBits = 0;
  int          txnCheck = 0;
  logic        txnLoad = 1'b0;
  logic [31:0] txnValue = 32'h0;
  logic [71:0] txnStream = 72'h0;
  logic [31:0] readDataExp = 32'h0;
  int          lastRespOffset = -1;
  int          oCyc;
  logic        eCs, eSck, eResp;

  always @(posedge clk) begin
    edgeCnt++;
    rstSampled = !rst_n;
  end

  // Offset 1 is the cycle right after acceptance; chip select spans 2B cycles, response follows.
  always @(negedge clk) if (edgeCnt > 0) begin
    if (rstSampled) begin
      readDataExp = 32'h0;
      eCs = 1'b1; eSck = 1'b0; eResp = 1'b0;
      checkOutput("mosi_in_reset", spi_mosi, 1'b0);
    end else begin
      oCyc  = edgeCnt - txnAccept + 1;
      eCs   = !(oCyc >= 1 && oCyc <= 2 * txnBits);
      eSck  = !eCs && (oCyc % 2 == 0);
      eResp = (oCyc == 2 * txnBits + 1);
      if (eResp && txnLoad) readDataExp = txnValue;
      if (!eCs && (oCyc % 2 == 1) && ((oCyc - 1) / 2 < txnCheck))
        checkOutput("mosi_bit", spi_mosi, txnStream[71 - (oCyc - 1) / 2]);
    end
    if (memory_response === 1'b1) lastRespOffset = edgeCnt - txnAccept + 1;
    checkOutput("cs_n", spi_cs_n, eCs);
    checkOutput("sck", spi_sck, eSck);
    checkOutput("response", memory_response, eResp);
    checkOutput("read_data", read_data, readDataExp);
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] opt,
                               input logic [31:0] addr, input logic [31:0] wd, input int abortAt);
    int          n, bits, chk;
    logic        valid;
    logic [7:0]  cmd;
    logic [71:0] stream;
    logic [31:0] raw, value;
    logic [16:0] base;
    valid  = !(opt == 3'b011 || opt == 3'b110 || opt == 3'b111);
    n      = (opt[1:0] == 2'b00) ? 1 : (opt[1:0] == 2'b01) ? 2 : 4;
    base   = addr[16:0];
    cmd    = wr ? 8'h02 : (FastBuild ? 8'h0B : 8'h03);
    stream = {cmd, 7'b0, base, 40'h0};
    raw    = 32'h0;
    for (int k = 0; k < n; k++) begin
      logic [16:0] ak = base + 17'(k);
      if (wr) begin
        if (valid) refMem[ak] = wd[8*k +: 8];
        stream[39 - 8*k -: 8] = wd[8*k +: 8];
      end else begin
        raw[8*k +: 8] = refMem[ak];
      end
    end
    if (!valid) value = 32'h0;
    else if (n == 1) value = (raw[7] && !opt[2]) ? {24'hFFFFFF, raw[7:0]} : {24'h0, raw[7:0]};
    else if (n == 2) value = (raw[15] && !opt[2]) ? {16'hFFFF, raw[15:0]} : {16'h0, raw[15:0]};
    else value = raw;
    bits = 32 + 8 * n + ((!wr && FastBuild) ? 8 : 0);
    chk  = wr ? bits : (FastBuild ? 40 : 32);

    @(posedge clk); #1;
    memory_read = rd; memory_write = wr; option = opt; address = addr; write_data = wd;
    txnAccept = edgeCnt + 1;
    txnBits   = valid ? bits : 0;
    txnCheck  = valid ? chk : 0;
    txnLoad   = !wr;
    txnValue  = value;
    txnStream = stream;
    lastRespOffset = -1;
    @(posedge clk);
    if (abortAt > 0) begin
      repeat (abortAt - 1) @(posedge clk);
      #1;
      rst_n = 1'b0; memory_read = 1'b0; memory_write = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      txnAccept = -100000; txnBits = 0; txnCheck = 0;
    end else begin
      repeat (2 * txnBits) @(posedge clk);
      #1;
      memory_read = 1'b0; memory_write = 1'b0;
    end
    @(negedge clk); #1;
  endtask

  initial begin
    logic [31:0] r, a;
    logic [16:0] low;
    int          mode;
    #2000000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [31:0] r, a;
    logic [16:0] low;
    int          mode;
    for (int i = 0; i < 131072; i++) begin
      r = $urandom();
      ramMem[i] = r[7:0];
      refMem[i] = r[7:0];
    end
    rst_n = 1'b0; memory_read = 1'b0; memory_write = 1'b0;
    option = 3'b000; address = 32'h0; write_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    checkOutput("reset_read_data", read_data, 32'h0);
    checkOutput("reset_cs_n", spi_cs_n, 1'b1);

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 0);
    checkOutput("sw_latency", lastRespOffset, 129);
    checkOutput("sw_bits", capBits, 64);
    checkOutput("sw_stream", capStream[63:0], 64'h02000100_EFBEADDE);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0);
    checkOutput("lw_latency", lastRespOffset, FastBuild ? 145 : 129);
    checkOutput("lw_data", read_data, 32'hDEADBEEF);

    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0);
    checkOutput("lb_data", read_data, 32'hFFFFFFDE);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0);
    checkOutput("lbu_data", read_data, 32'h000000DE);

    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0200, 32'h000080FF, 0);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0, 0);
    checkOutput("lh_data", read_data, 32'hFFFF80FF);

    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0001_0005, 32'h12345678, 0);
    checkOutput("sb_latency", lastRespOffset, 81);
    checkOutput("sb_bits", capBits, 40);
    checkOutput("sb_stream", capStream[39:0], 40'h02_010005_78);
    checkOutput("sb_keeps_read_data", read_data, 32'hFFFF80FF);

    applyStimulus(1'b1, 1'b0, 3'b111, 32'h0000_0100, 32'h0, 0);
    checkOutput("invalid_latency", lastRespOffset, 1);
    checkOutput("invalid_read_data", read_data, 32'h0);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 30);
    checkOutput("abort_no_response", lastRespOffset, -1);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hCAFEF00D, 0);
    checkOutput("post_reset_sw_latency", lastRespOffset, 129);

    for (int t = 0; t < 40; t++) begin
      r    = $urandom();
      low  = ($urandom_range(0, 1) == 0) ? 17'($urandom_range(0, 63))
                                         : 17'(17'h1FFF8 + 17'($urandom_range(0, 7)));
      a    = {r[31:17], low};
      mode = $urandom_range(0, 3);
      applyStimulus(mode != 1, mode == 1 || mode == 2, 3'($urandom_range(0, 7)), a, $urandom(), 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
